// File: rtl/instr_mem_loader_if.sv
// Signal bundle between an instruction-field producer, the loader and instruction memory.
// The slave modport is the loader's view; the master modport is the producer/memory side.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              valid_i;
  logic              ready_o;
  logic [5:0]        op_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic [4:0]        shamt_i;
  logic [5:0]        funct_i;
  logic [15:0]       imm_i;
  logic              clear_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_ack_i;
  logic [CountW-1:0] count_o;
  logic              full_o;
  logic              err_o;

  modport slave (
    input  valid_i, op_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, clear_i, mem_ack_i,
    output ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
  );

  modport master (
    output valid_i, op_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, clear_i, mem_ack_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes R/lw/sw/beq field descriptions into MIPS words and writes them to sequential
// word addresses in instruction memory over a write/ack handshake.
module instr_mem_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_mem_loader_if.slave  bus
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [CountW-1:0] count_q;
  logic              full_q;
  logic              err_q;

  logic              legal;
  logic [31:0]       enc_word;
  logic [CountW-1:0] count_inc;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    legal    = 1'b0;
    enc_word = {bus.op_i, bus.rs_i, bus.rt_i, bus.imm_i};
    unique case (bus.op_i)
      6'h00: begin
        legal    = 1'b1;
        enc_word = {bus.op_i, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
      end
      6'h23, 6'h2B, 6'h04: legal = 1'b1;
      default:             legal = 1'b0;
    endcase
  end

  assign count_inc = count_q + CountW'(1);
  // Address wraps modulo 2^ADDR_W only; there is no wrap inside DEPTH.
  assign next_addr = BASE_ADDR + (ADDR_W'(count_q) << 2);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.clear_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            ready_q <= 1'b1;
          end else if (bus.valid_i) begin
            if (legal) begin
              data_q  <= enc_word;
              addr_q  <= next_addr;
              we_q    <= 1'b1;
              ready_q <= 1'b0;
              state_q <= StWrite;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          // clear_i is deliberately ignored here so an issued write always completes.
          if (bus.mem_ack_i) begin
            we_q    <= 1'b0;
            count_q <= count_inc;
            if (count_inc == CountW'(DEPTH)) begin
              full_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= StFull;
            end else begin
              ready_q <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StFull: begin
          if (bus.clear_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.count_o    = count_q;
  assign bus.full_o     = full_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (DEPTH=4): vector table plus hand-written
// sequences for full/clear, clear-during-write and asynchronous reset mid-write.
module tb_instr_mem_loader;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_mem_loader_if #(.ADDR_W(32), .DEPTH(4)) bus ();

  instr_mem_loader #(
    .ADDR_W   (32),
    .DEPTH    (4),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    int          delay;
    logic        legal;
    logic [31:0] data;
    logic [31:0] addr;
    int          cnt;
    logic        full;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.op_i    = v.op;
    bus.rs_i    = v.rs;
    bus.rt_i    = v.rt;
    bus.rd_i    = v.rd;
    bus.shamt_i = v.shamt;
    bus.funct_i = v.funct;
    bus.imm_i   = v.imm;
    bus.valid_i = 1'b1;
  endtask

  // Presents one vector; illegal vectors leave valid_i high so the next one follows back-to-back.
  task automatic do_vec(input vec_t v);
    drive(v);
    step();
    if (v.legal) begin
      chk("we_set", 32'(bus.mem_we_o), 32'd1);
      chk("addr", bus.mem_addr_o, v.addr);
      chk("data", bus.mem_data_o, v.data);
      chk("ready_busy", 32'(bus.ready_o), 32'd0);
      chk("err_quiet", 32'(bus.err_o), 32'd0);
      bus.valid_i = 1'b0;
      for (int k = 0; k < v.delay; k++) begin
        step();
        chk("we_hold", 32'(bus.mem_we_o), 32'd1);
        chk("addr_hold", bus.mem_addr_o, v.addr);
        chk("data_hold", bus.mem_data_o, v.data);
      end
      bus.mem_ack_i = 1'b1;
      step();
      bus.mem_ack_i = 1'b0;
      chk("we_clr", 32'(bus.mem_we_o), 32'd0);
      chk("count", 32'(bus.count_o), 32'(v.cnt));
      chk("full", 32'(bus.full_o), 32'(v.full));
      chk("ready_after", 32'(bus.ready_o), 32'(!v.full));
    end else begin
      chk("err_pulse", 32'(bus.err_o), 32'd1);
      chk("we_illegal", 32'(bus.mem_we_o), 32'd0);
      chk("ready_illegal", 32'(bus.ready_o), 32'd1);
      chk("count_illegal", 32'(bus.count_o), 32'(v.cnt));
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    //            op     rs    rt     rd     shamt  funct  imm        dly lg    data          addr   cnt full
    vecs[0] = '{6'h23, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 3, 1'b1, 32'h8D280004, 32'h0, 1, 1'b0};
    vecs[1] = '{6'h2B, 5'd9, 5'd8, 5'd0,  5'd0,  6'h00, 16'h0008, 3, 1'b1, 32'hAD280008, 32'h4, 2, 1'b0};
    vecs[2] = '{6'h04, 5'd1, 5'd2, 5'd0,  5'd0,  6'h00, 16'hFFFF, 3, 1'b1, 32'h1022FFFF, 32'h8, 3, 1'b0};
    vecs[3] = '{6'h3F, 5'd1, 5'd2, 5'd3,  5'd0,  6'h20, 16'h1234, 0, 1'b0, 32'h0,        32'h0, 3, 1'b0};
    vecs[4] = '{6'h3F, 5'd4, 5'd5, 5'd6,  5'd0,  6'h20, 16'h5678, 0, 1'b0, 32'h0,        32'h0, 3, 1'b0};
    vecs[5] = '{6'h00, 5'd1, 5'd2, 5'd3,  5'd0,  6'h20, 16'hFFFF, 0, 1'b1, 32'h00221820, 32'hC, 4, 1'b1};

    rst_n         = 1'b0;
    bus.valid_i   = 1'b0;
    bus.op_i      = '0;
    bus.rs_i      = '0;
    bus.rt_i      = '0;
    bus.rd_i      = '0;
    bus.shamt_i   = '0;
    bus.funct_i   = '0;
    bus.imm_i     = '0;
    bus.clear_i   = 1'b0;
    bus.mem_ack_i = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_data", bus.mem_data_o, 32'h0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) do_vec(vecs[i]);

    // FULL: valid and ack are ignored until clear.
    drive(vecs[5]);
    step();
    step();
    chk("full_we", 32'(bus.mem_we_o), 32'd0);
    chk("full_ready", 32'(bus.ready_o), 32'd0);
    chk("full_flag", 32'(bus.full_o), 32'd1);
    chk("full_count", 32'(bus.count_o), 32'd4);
    bus.valid_i   = 1'b0;
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    chk("full_ack_ignored", 32'(bus.count_o), 32'd4);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    chk("clr_count", 32'(bus.count_o), 32'd0);
    chk("clr_full", 32'(bus.full_o), 32'd0);
    chk("clr_ready", 32'(bus.ready_o), 32'd1);
    chk("clr_addr", bus.mem_addr_o, 32'h0);
    v = vecs[5];
    v.addr = 32'h0;
    v.cnt  = 1;
    v.full = 1'b0;
    do_vec(v);

    // clear_i wins over a simultaneous valid_i in IDLE.
    drive(vecs[0]);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("prio_we", 32'(bus.mem_we_o), 32'd0);
    chk("prio_count", 32'(bus.count_o), 32'd0);
    chk("prio_ready", 32'(bus.ready_o), 32'd1);

    // clear_i during WRITE is ignored; the write completes and is counted.
    drive(vecs[0]);
    step();
    chk("cw_we", 32'(bus.mem_we_o), 32'd1);
    chk("cw_addr", bus.mem_addr_o, 32'h0);
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b1;
    step();
    step();
    chk("cw_we_hold", 32'(bus.mem_we_o), 32'd1);
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    bus.clear_i   = 1'b0;
    chk("cw_count", 32'(bus.count_o), 32'd1);
    chk("cw_we_clr", 32'(bus.mem_we_o), 32'd0);
    chk("cw_ready", 32'(bus.ready_o), 32'd1);
    step();
    chk("cw_count_keep", 32'(bus.count_o), 32'd1);

    // Single illegal opcode then valid dropped: err_o lasts exactly one cycle.
    drive(vecs[3]);
    step();
    chk("err_one", 32'(bus.err_o), 32'd1);
    bus.valid_i = 1'b0;
    step();
    chk("err_gone", 32'(bus.err_o), 32'd0);
    chk("err_count", 32'(bus.count_o), 32'd1);

    // Asynchronous reset in the middle of a write.
    drive(vecs[1]);
    step();
    chk("rw_we", 32'(bus.mem_we_o), 32'd1);
    chk("rw_addr", bus.mem_addr_o, 32'h4);
    bus.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.mem_we_o), 32'd0);
    chk("arst_count", 32'(bus.count_o), 32'd0);
    chk("arst_ready", 32'(bus.ready_o), 32'd1);
    chk("arst_addr", bus.mem_addr_o, 32'h0);
    chk("arst_data", bus.mem_data_o, 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.ready_o), 32'd1);
    chk("post_rst_we", 32'(bus.mem_we_o), 32'd0);
    v = vecs[5];
    v.addr = 32'h0;
    v.cnt  = 1;
    v.full = 1'b0;
    do_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
